// File: rtl/bram_stream_reader.sv
// ---------------------------------------------------------------------------
// bram_stream_reader
//
// Turns the contents of a BRAM ring (written by an external producer) into a
// valid/ready stream. The producer advances wptr each time it commits an
// entry; this block issues reads at iptr, catches the returned words in a
// two-entry skid buffer, and presents them on out_valid/out_data. The
// committed read count rptr goes back to the producer for its full check.
//
// The BRAM has one cycle of read latency. A single inflight flag tracks the
// read issued on the previous edge. Reads are only issued when the word is
// sure to have a free buffer slot when it lands, so the buffer never
// overflows. This allows one entry per cycle under sustained out_ready.
//
// Parameters
//   DATA_WIDTH  entry width in bits
//   ADDR_WIDTH  BRAM address width
//   RAM_DEPTH   ring depth, must equal 1 << ADDR_WIDTH
//
// Ports
//   clk         clock, all logic on the rising edge
//   rst         asynchronous active-high reset (control state only)
//   wptr        producer write count, ADDR_WIDTH+1 bits (wrap bit on top)
//   flush       synchronous discard of every unread entry
//   bram_ren    BRAM read enable (combinational)
//   bram_raddr  BRAM read address (combinational, low bits of iptr)
//   bram_rdata  BRAM read data, valid the cycle after bram_ren
//   out_valid   stream data valid
//   out_ready   consumer ready
//   out_data    stream data, head of the output buffer
//   rptr        committed read count, ADDR_WIDTH+1 bits
//   level       wptr - rptr, modulo 2^(ADDR_WIDTH+1)
// ---------------------------------------------------------------------------
module bram_stream_reader #(
    parameter int DATA_WIDTH = 4000,
    parameter int ADDR_WIDTH = 3,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic                  flush,
    output logic                  bram_ren,
    output logic [ADDR_WIDTH-1:0] bram_raddr,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int              PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    // The pointer arithmetic relies on the ring wrapping exactly at the
    // address width, so any other depth is refused at elaboration.
    generate
        if (RAM_DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
            $error("bram_stream_reader: RAM_DEPTH must equal 1 << ADDR_WIDTH");
        end
    endgenerate

    // True when a read issued now is guaranteed a buffer slot on arrival:
    // words already held plus the one in flight, less any leaving this
    // edge, must stay below the buffer capacity of two.
    function automatic logic has_room(input logic [1:0] cnt,
                                      input logic       infl,
                                      input logic       pp);
        logic [2:0] occ;
        logic [2:0] lim;
        occ = {1'b0, cnt} + {2'b00, infl};
        lim = 3'd2 + {2'b00, pp};
        return occ < lim;
    endfunction

    // Issue stage state (p0): next ring slot to read.
    logic [PW-1:0]         iptr_p0;
    // Read-return stage state (p1): a word arrives on bram_rdata this cycle.
    logic                  inflight_p1;
    // Output buffer state (p2): occupancy plus head/tail words.
    logic [1:0]            buf_count_p2;
    logic [DATA_WIDTH-1:0] buf_head_p2;
    logic [DATA_WIDTH-1:0] buf_tail_p2;
    logic [PW-1:0]         rptr_q;

    logic                  avail;
    logic                  pop;
    logic                  append;

    assign avail      = (wptr != iptr_p0);
    assign out_valid  = (buf_count_p2 != 2'd0) && !flush && !rst;
    assign out_data   = buf_head_p2;
    assign pop        = out_valid && out_ready;
    // A word returning during flush belongs to the discarded stream.
    assign append     = inflight_p1 && !flush;

    assign bram_ren   = !rst && avail && !flush
                        && has_room(buf_count_p2, inflight_p1, pop);
    assign bram_raddr = iptr_p0[ADDR_WIDTH-1:0];

    assign rptr       = rptr_q;
    assign level      = wptr - rptr_q;

    // ---- p0 -> p1: issue a read, advance iptr, mark a word in flight ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iptr_p0     <= '0;
            inflight_p1 <= 1'b0;
        end else if (flush) begin
            iptr_p0     <= wptr;
            inflight_p1 <= 1'b0;
        end else begin
            inflight_p1 <= bram_ren;
            if (bram_ren) begin
                iptr_p0 <= iptr_p0 + PTR_ONE;
            end
        end
    end

    // ---- p1 -> p2: buffer occupancy and committed read count ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_count_p2 <= 2'd0;
            rptr_q       <= '0;
        end else if (flush) begin
            buf_count_p2 <= 2'd0;
            rptr_q       <= wptr;
        end else begin
            unique case ({append, pop})
                2'b10:   buf_count_p2 <= buf_count_p2 + 2'd1;
                2'b01:   buf_count_p2 <= buf_count_p2 - 2'd1;
                default: buf_count_p2 <= buf_count_p2;
            endcase
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    // Buffer words carry no reset: occupancy alone says which are live.
    // A simultaneous pop and append shifts the tail forward and lands the
    // new word behind it, so nothing is lost or duplicated.
    always_ff @(posedge clk) begin
        unique case ({append, pop})
            2'b11: begin
                if (buf_count_p2 == 2'd2) begin
                    buf_head_p2 <= buf_tail_p2;
                    buf_tail_p2 <= bram_rdata;
                end else begin
                    buf_head_p2 <= bram_rdata;
                end
            end
            2'b01: begin
                buf_head_p2 <= buf_tail_p2;
            end
            2'b10: begin
                if (buf_count_p2 == 2'd0) begin
                    buf_head_p2 <= bram_rdata;
                end else begin
                    buf_tail_p2 <= bram_rdata;
                end
            end
            default: begin
                buf_head_p2 <= buf_head_p2;
            end
        endcase
    end

endmodule

// File: doc/bram_stream_reader.md
BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4000, the entry width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, the BRAM address width.
REQ-003 SHALL have parameter RAM_DEPTH, default 1<<ADDR_WIDTH, the ring depth; only powers of two are supported.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is posedge clk.
REQ-005 SHALL have port rst, input, 1 bit, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port wptr, input, ADDR_WIDTH+1 bits, the producer write count; it increments on the same edge the BRAM write commits.
REQ-007 SHALL have port flush, input, 1 bit, a synchronous discard of all unread entries.
REQ-008 SHALL have port bram_ren, output, 1 bit, the BRAM read enable, combinational.
REQ-009 SHALL have port bram_raddr, output, ADDR_WIDTH bits, the BRAM read address, combinational.
REQ-010 SHALL have port bram_rdata, input, DATA_WIDTH bits, the BRAM read data; it is valid the cycle after bram_ren.
REQ-011 SHALL have port out_valid, output, 1 bit, indicating the stream data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit, the consumer ready.
REQ-013 SHALL have port out_data, output, DATA_WIDTH bits, the stream data.
REQ-014 SHALL have port rptr, output, ADDR_WIDTH+1 bits, the committed read count returned to the producer for full detection.
REQ-015 SHALL have port level, output, ADDR_WIDTH+1 bits, equal to wptr-rptr mod 2^(ADDR_WIDTH+1).

Function
REQ-016 SHALL keep an issue pointer iptr of ADDR_WIDTH+1 bits; bram_raddr = iptr[ADDR_WIDTH-1:0].
REQ-017 SHALL keep a 2-entry output buffer (head first) plus a 1-bit inflight flag.
REQ-018 SHALL compute pop = out_valid && out_ready, and avail = (wptr != iptr).
REQ-019 SHALL assert bram_ren = avail && !flush && (buf_count + inflight - pop < 2).
REQ-020 SHALL, on an edge where bram_ren is high, increment iptr with modulo wrap and set inflight, and otherwise clear inflight.
REQ-021 SHALL, on an edge where inflight is high, append bram_rdata to the output buffer.
REQ-022 SHALL, when a pop and an append occur on the same edge, shift out the head and append the new entry with no loss.
REQ-023 SHALL drive out_valid = (buf_count != 0), with out_data as the buffer head.
REQ-024 SHALL keep out_data stable while out_valid && !out_ready.
REQ-025 SHALL increment rptr by 1 per pop, with modulo wrap.
REQ-026 SHALL give a first-word latency of 2 cycles: wptr changes at edge E, bram_ren is high in the cycle after E, and out_valid is high after edge E+2.
REQ-027 SHALL sustain 1 entry per cycle while out_ready stays high and avail holds.
REQ-028 SHALL NOT issue when wptr == iptr (empty); pointer wrap from 2^(ADDR_WIDTH+1)-1 to 0 SHALL be seamless.
REQ-029 SHALL NOT check fullness; the producer guarantees level <= RAM_DEPTH.
REQ-030 SHALL, on an edge where flush is high: clear the buffer and inflight, load iptr and rptr from wptr, and discard any pop that cycle.
REQ-031 SHALL, while flush is high, hold bram_ren and out_valid low.
REQ-032 SHALL treat the BRAM as read-old-on-collision; by REQ-006 an entry is never read on its write edge.

Reset
REQ-033 SHALL, on assertion of rst, immediately (asynchronously) clear iptr, rptr, buffer count and inflight to 0.
REQ-034 SHALL, during reset, hold out_valid at 0 and bram_ren at 0 (the latter gated by rst); level then equals wptr.
REQ-035 SHALL treat reset mid-stream as discarding all buffered and inflight data; the BRAM contents are untouched.
REQ-036 SHALL begin normal issue on the first edge after rst deasserts.

Verification (DATA_WIDTH=8, ADDR_WIDTH=3)
REQ-037 SHALL cover single entry: write 0xA5 at addr 0, wptr 0->1 at edge E, out_ready=1 -> bram_ren=1 and raddr=0 in the cycle after E; out_valid=1 and out_data=0xA5 after E+2; rptr=1 the edge after.
REQ-038 SHALL cover streaming: 8 entries 0x10..0x17, wptr=8, out_ready=1 -> 8 consecutive valid beats in order, with no bubble after the first.
REQ-039 SHALL cover backpressure: out_ready=0 with 8 entries -> buffer holds 2, bram_ren=0, out_data=0x10 stable; on release, order is preserved and there are no duplicates.
REQ-040 SHALL cover wrap: 20 entries pushed in batches of 8 or fewer -> all 20 received in order, and rptr ends at 20 mod 16 = 4.
REQ-041 SHALL cover flush: level=5 with 2 entries buffered, flush pulsed -> out_valid=0 next cycle, rptr=iptr=wptr, level=0.
REQ-042 SHALL cover async reset mid-stream: rst asserted between edges -> out_valid, rptr and level reflect 0 state immediately, and no beat appears until wptr advances after reset.
